// File: rtl/bcd_seg_scan.sv
// Four-digit multiplexed 7-segment driver for BCD data, with frame-synchronous
// update of the displayed value, leading-zero blanking and per-digit decimal points.
module bcd_seg_scan #(
   parameter int DIV = 1000,
   parameter int GAP = 2
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic [15:0] din,
   input  logic        upd,
   input  logic [3:0]  dp_en,
   input  logic        blank_lz,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame
);

   localparam int CMAX = (DIV > GAP) ? DIV : GAP;
   localparam int CW   = $clog2(CMAX);

   typedef enum logic {ST_GAP = 1'b0, ST_SHOW = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   pnd_q, pnd_d;
   logic          pf_q, pf_d;
   logic [15:0]   act_q, act_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic          frame_q, frame_d;

   logic          boundary;
   logic [15:0]   upper;
   logic          blank;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= ST_GAP;
         cnt_q   <= '0;
         idx_q   <= 2'd3;
         pnd_q   <= '0;
         pf_q    <= 1'b0;
         act_q   <= '0;
         an_q    <= 4'b1111;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         pnd_q   <= pnd_d;
         pf_q    <= pf_d;
         act_q   <= act_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         frame_q <= frame_d;
      end
   end

   // The frame boundary is the GAP->SHOW transition that wraps the digit index to 0.
   assign boundary = (state_q == ST_GAP) && (cnt_q == CW'(GAP - 1)) && (idx_q == 2'd3);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      pnd_d   = pnd_q;
      pf_d    = pf_q;
      act_d   = act_q;
      if (state_q == ST_SHOW) begin
         if (cnt_q == CW'(DIV - 1)) begin
            state_d = ST_GAP;
            cnt_d   = '0;
         end
      end else begin
         if (cnt_q == CW'(GAP - 1)) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
         end
      end
      if (boundary && pf_q)
         act_d = pnd_q;
      if (upd) begin
         pnd_d = din;
         pf_d  = 1'b1;
      end else if (boundary) begin
         pf_d  = 1'b0;
      end
   end

   // A digit blanks when it and every more significant digit are zero.
   assign upper = act_q >> {idx_q, 2'b00};
   assign blank = blank_lz && (idx_q != 2'd0) && (upper == 16'd0);

   always_comb begin
      an_d    = 4'b1111;
      seg_d   = 7'h7F;
      dp_d    = 1'b1;
      frame_d = boundary;
      if (state_q == ST_SHOW) begin
         an_d = ~(4'b0001 << idx_q);
         if (!blank) begin
            seg_d = decode(upper[3:0]);
            dp_d  = ~dp_en[idx_q];
         end
      end
   end

   assign an    = an_q;
   assign seg   = seg_q;
   assign dp    = dp_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan: schedule-based reference model checked every
// cycle, a table of display vectors, and hand-built sequences for boundary/reset cases.
module tb_bcd_seg_scan;

   localparam int DIV  = 4;
   localparam int GP   = 2;
   localparam int SLOT = DIV + GP;
   localparam int FR   = 4 * SLOT;

   logic        clk = 1'b0;
   logic        clr_n;
   logic [15:0] din;
   logic        upd;
   logic [3:0]  dp_en;
   logic        blank_lz;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame;

   always #5 clk = ~clk;

   bcd_seg_scan #(.DIV(DIV), .GAP(GP)) dut (
      .clk      (clk),
      .clr_n    (clr_n),
      .din      (din),
      .upd      (upd),
      .dp_en    (dp_en),
      .blank_lz (blank_lz),
      .an       (an),
      .seg      (seg),
      .dp       (dp),
      .frame    (frame)
   );

   typedef struct packed {
      logic [15:0] din;
      logic [3:0]  dp_en;
      logic        blank_lz;
      logic [6:0]  s0;
      logic [6:0]  s1;
      logic [6:0]  s2;
      logic [6:0]  s3;
      logic [3:0]  dpx;
   } vec_t;

   vec_t        vecs [8];
   logic [6:0]  dec_tbl [16];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          t;
   int          t_prev;
   logic [15:0] m_act, m_pnd;
   logic        m_pf;

   // Position in the display schedule after tt clock edges since reset release.
   function automatic void sched(input int tt, output logic shw, output int ix);
      int s;
      s = tt - GP;
      if (s < 0) begin
         shw = 1'b0;
         ix  = 3;
      end else begin
         shw = (s % SLOT) < DIV;
         ix  = (s / SLOT) % 4;
      end
   endfunction

   function automatic logic is_bnd(input int tt);
      return (tt >= GP) && (((tt - GP) % FR) == 0);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         if (n_bad <= 30)
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      logic        shw;
      int          ix;
      logic [3:0]  ean;
      logic [6:0]  eseg;
      logic        edp, efr, blk;
      logic [15:0] up;
      @(posedge clk);
      #1;
      ean  = 4'b1111;
      eseg = 7'h7F;
      edp  = 1'b1;
      efr  = 1'b0;
      if (!clr_n) begin
         t = 0; m_act = '0; m_pnd = '0; m_pf = 1'b0;
      end else begin
         sched(t, shw, ix);
         if (shw) begin
            up   = m_act >> (4 * ix);
            blk  = blank_lz && (ix != 0) && (up == 16'd0);
            ean  = ~(4'b0001 << ix);
            eseg = blk ? 7'h7F : dec_tbl[up[3:0]];
            edp  = blk ? 1'b1 : ~dp_en[ix];
         end
         t++;
         efr = is_bnd(t);
         if (efr && m_pf) m_act = m_pnd;
         if (upd) begin
            m_pnd = din; m_pf = 1'b1;
         end else if (efr) begin
            m_pf = 1'b0;
         end
      end
      check("cycle", {20'd0, an, seg, dp, frame}, {20'd0, ean, eseg, edp, efr});
   endtask

   task automatic wait_frame();
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (frame !== 1'b1 && k < 100);
      check("frame_timeout", {31'd0, frame}, 32'd1);
   endtask

   // Called just after a frame pulse; samples the first cycle of each digit slot.
   task automatic check_slots(input vec_t v);
      logic [6:0] es [4];
      es[0] = v.s0; es[1] = v.s1; es[2] = v.s2; es[3] = v.s3;
      step();
      for (int i = 0; i < 4; i++) begin
         check("slot_an",  {28'd0, an},  {28'd0, ~(4'b0001 << i)});
         check("slot_seg", {25'd0, seg}, {25'd0, es[i]});
         check("slot_dp",  {31'd0, dp},  {31'd0, v.dpx[i]});
         if (i < 3) repeat (SLOT) step();
      end
   endtask

   initial begin
      dec_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
      vecs[0] = '{16'h0000, 4'b0000, 1'b0, 7'h40, 7'h40, 7'h40, 7'h40, 4'b1111};
      vecs[1] = '{16'h1234, 4'b0000, 1'b0, 7'h19, 7'h30, 7'h24, 7'h79, 4'b1111};
      vecs[2] = '{16'h0007, 4'b0000, 1'b1, 7'h78, 7'h7F, 7'h7F, 7'h7F, 4'b1111};
      vecs[3] = '{16'h0070, 4'b0000, 1'b1, 7'h40, 7'h78, 7'h7F, 7'h7F, 4'b1111};
      vecs[4] = '{16'h00AF, 4'b0001, 1'b0, 7'h3F, 7'h3F, 7'h40, 7'h40, 4'b1110};
      vecs[5] = '{16'h5689, 4'b1010, 1'b0, 7'h10, 7'h00, 7'h02, 7'h12, 4'b0101};
      vecs[6] = '{16'h0000, 4'b1111, 1'b1, 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b1110};
      vecs[7] = '{16'h0100, 4'b0000, 1'b1, 7'h40, 7'h40, 7'h79, 7'h7F, 4'b1111};

      clr_n = 1'b0; upd = 1'b0; din = '0; dp_en = '0; blank_lz = 1'b0;
      t = 0; m_act = '0; m_pnd = '0; m_pf = 1'b0;
      repeat (3) step();
      clr_n = 1'b1;

      // Startup: first boundary after GP clocks, then all zeros, then frame period.
      wait_frame();
      check("first_frame_t", t, GP);
      t_prev = t;
      check_slots(vecs[0]);
      wait_frame();
      check("frame_period", t - t_prev, FR);

      for (int v = 0; v < 8; v++) begin
         wait_frame();
         step();
         din = vecs[v].din; dp_en = vecs[v].dp_en; blank_lz = vecs[v].blank_lz; upd = 1'b1;
         step();
         upd = 1'b0;
         wait_frame();
         check_slots(vecs[v]);
      end

      // Second update lands on the boundary edge: 1111 shows first, 2222 one frame later.
      dp_en = '0; blank_lz = 1'b0;
      wait_frame();
      step();
      din = 16'h1111; upd = 1'b1;
      step();
      upd = 1'b0;
      repeat (FR - 3) step();
      din = 16'h2222; upd = 1'b1;
      step();
      upd = 1'b0;
      check("coincident_frame", {31'd0, frame}, 32'd1);
      check_slots('{16'h1111, 4'b0000, 1'b0, 7'h79, 7'h79, 7'h79, 7'h79, 4'b1111});
      wait_frame();
      check_slots('{16'h2222, 4'b0000, 1'b0, 7'h24, 7'h24, 7'h24, 7'h24, 4'b1111});

      // Asynchronous reset in the middle of digit 2's slot, with an update pending.
      wait_frame();
      din = 16'h9999; upd = 1'b1;
      step();
      upd = 1'b0;
      repeat (2 * SLOT) step();
      check("pre_reset_an", {28'd0, an}, {28'd0, 4'b1011});
      #2 clr_n = 1'b0;
      #1;
      check("async_reset", {20'd0, an, seg, dp, frame}, {20'd0, 4'b1111, 7'h7F, 1'b1, 1'b0});
      repeat (2) step();
      clr_n = 1'b1;
      wait_frame();
      check("restart_frame_t", t, GP);
      check_slots(vecs[0]);

      for (int n = 0; n < 500; n++) begin
         for (int d = 0; d < 4; d++)
            din[4*d +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         upd = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) dp_en = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 199) == 0) clr_n = 1'b0;
         step();
         clr_n = 1'b1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
